// File: rtl/pwm_soft_start_ctrl_if.sv
// Control and status bundle between the pin-side sequencer inputs and the PWM generator.
interface pwm_soft_start_ctrl_if #(
    parameter int SPEED_W = 3
);
    logic               enable;
    logic [SPEED_W-1:0] speed_target;
    logic               estop;
    logic [SPEED_W-1:0] speed_cmd;
    logic               pwm_en;
    logic               ramping;
    logic               at_target;
    logic               fault;

    modport master (
        output enable, speed_target, estop,
        input  speed_cmd, pwm_en, ramping, at_target, fault
    );

    modport slave (
        input  enable, speed_target, estop,
        output speed_cmd, pwm_en, ramping, at_target, fault
    );
endinterface

// File: rtl/pwm_soft_start_ctrl.sv
// Soft-start/stop sequencer: walks speed_cmd +/-1 toward the target every STEP_CYCLES clocks.
// Latency: first step STEP_CYCLES cycles after ramp entry; level inputs, no backpressure.
module pwm_soft_start_ctrl #(
    parameter int SPEED_W     = 3,
    parameter int STEP_CYCLES = 1000,
    parameter int TMR_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_soft_start_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RAMP  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    localparam logic [TMR_W-1:0] STEP_LAST = TMR_W'(STEP_CYCLES - 1);

    logic [1:0]         state;
    logic [SPEED_W-1:0] cmd;
    logic               pwm_en_q;
    logic [TMR_W-1:0]   timer;
    logic [SPEED_W-1:0] tgt;
    logic [SPEED_W-1:0] cmd_step;
    logic               step_due;

    assign tgt      = bus.enable ? bus.speed_target : '0;
    assign step_due = (timer == STEP_LAST);
    // Only used when cmd != tgt, so the +1/-1 can never leave 0..2**SPEED_W-1.
    assign cmd_step = (cmd < tgt) ? cmd + SPEED_W'(1) : cmd - SPEED_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= '0;
            pwm_en_q <= 1'b0;
            timer    <= '0;
        end else if (bus.estop) begin
            state    <= FAULT;
            cmd      <= '0;
            pwm_en_q <= 1'b0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd      <= '0;
                    pwm_en_q <= 1'b0;
                    timer    <= '0;
                    if (bus.enable && bus.speed_target != '0) begin
                        state    <= RAMP;
                        pwm_en_q <= 1'b1;
                    end
                end
                RAMP: begin
                    if (cmd == tgt) begin
                        timer <= '0;
                        if (tgt != '0) begin
                            state <= RUN;
                        end else begin
                            state    <= IDLE;
                            pwm_en_q <= 1'b0;
                        end
                    end else if (step_due) begin
                        timer <= '0;
                        cmd   <= cmd_step;
                        // Landing on zero while stopping shuts the generator off on the same edge.
                        if (cmd_step == '0 && tgt == '0) begin
                            state    <= IDLE;
                            pwm_en_q <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                RUN: begin
                    if (tgt != cmd) begin
                        state <= RAMP;
                        timer <= '0;
                    end
                end
                FAULT: begin
                    cmd      <= '0;
                    pwm_en_q <= 1'b0;
                    timer    <= '0;
                    if (!bus.enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cmd      <= '0;
                    pwm_en_q <= 1'b0;
                    timer    <= '0;
                end
            endcase
        end
    end

    assign bus.speed_cmd = cmd;
    assign bus.pwm_en    = pwm_en_q;
    assign bus.ramping   = (state == RAMP);
    assign bus.at_target = (state == RUN);
    assign bus.fault     = (state == FAULT);
endmodule

// File: tb/tb_pwm_soft_start_ctrl.sv
// Bench for pwm_soft_start_ctrl: directed scenarios plus random stimulus against a step-schedule model.
module tb_pwm_soft_start_ctrl;
    localparam int SW = 3;
    localparam int TW = 16;
    localparam int M_IDLE = 0, M_RAMP = 1, M_RUN = 2, M_FAULT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_soft_start_ctrl_if #(.SPEED_W(SW)) a_if ();
    pwm_soft_start_ctrl_if #(.SPEED_W(SW)) b_if ();

    pwm_soft_start_ctrl #(.SPEED_W(SW), .STEP_CYCLES(4), .TMR_W(TW)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));
    pwm_soft_start_ctrl #(.SPEED_W(SW), .STEP_CYCLES(1), .TMR_W(TW)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));

    // Model: mode plus the absolute cycle at which the next step is scheduled.
    typedef struct {
        int     st;
        int     cmd;
        longint due;
    } model_t;

    model_t ma, mb;
    longint cyc = 0;
    int errors = 0;
    int checks = 0;

    function automatic model_t step_model(model_t m, int step, bit r, bit en, int req, bit es, longint now);
        model_t n;
        int tgt;
        n = m;
        tgt = en ? req : 0;
        if (r) begin
            n.st = M_IDLE; n.cmd = 0;
        end else if (es) begin
            n.st = M_FAULT; n.cmd = 0;
        end else begin
            case (m.st)
                M_IDLE: if (en && req != 0) begin n.st = M_RAMP; n.due = now + step; end
                M_RAMP: begin
                    if (m.cmd == tgt) n.st = (tgt != 0) ? M_RUN : M_IDLE;
                    else if (now == m.due) begin
                        n.cmd = m.cmd + ((m.cmd < tgt) ? 1 : -1);
                        n.due = now + step;
                        if (n.cmd == 0 && tgt == 0) n.st = M_IDLE;
                    end
                end
                M_RUN: if (tgt != m.cmd) begin n.st = M_RAMP; n.due = now + step; end
                default: if (!en) n.st = M_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic logic [6:0] exp_vec(model_t m);
        logic [2:0] c;
        c = 3'(m.cmd);
        return {c, (m.st == M_RAMP || m.st == M_RUN), (m.st == M_RAMP), (m.st == M_RUN), (m.st == M_FAULT)};
    endfunction

    function automatic logic [6:0] a_vec();
        return {a_if.speed_cmd, a_if.pwm_en, a_if.ramping, a_if.at_target, a_if.fault};
    endfunction

    function automatic logic [6:0] b_vec();
        return {b_if.speed_cmd, b_if.pwm_en, b_if.ramping, b_if.at_target, b_if.fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        ma = step_model(ma, 4, rst, a_if.enable, int'(a_if.speed_target), a_if.estop, cyc);
        mb = step_model(mb, 1, rst, b_if.enable, int'(b_if.speed_target), b_if.estop, cyc);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.enable = 1'b1; a_if.speed_target = 3'd5; a_if.estop = 1'b1;
        b_if.enable = 1'b0; b_if.speed_target = 3'd0; b_if.estop = 1'b0;
        tick(); tick();
        if (a_vec() !== 7'b0) begin errors++; $display("FAIL reset_a got=%b exp=%b", a_vec(), 7'b0); end
        checks++;
        if (b_vec() !== 7'b0) begin errors++; $display("FAIL reset_b got=%b exp=%b", b_vec(), 7'b0); end
        checks++;
        a_if.enable = 1'b0; a_if.speed_target = 3'd0; a_if.estop = 1'b0;
        rst = 1'b0;
        tick();
        if (a_vec() !== exp_vec(ma)) begin errors++; $display("FAIL reset_idle got=%b exp=%b", a_vec(), exp_vec(ma)); end
        checks++;
    endtask

    task automatic test_ramp_up();
        longint e;
        a_if.enable = 1'b1; a_if.speed_target = 3'd5;
        tick();
        e = cyc;
        if (a_if.pwm_en !== 1'b1) begin errors++; $display("FAIL ramp_up_pwm_en got=%b exp=1", a_if.pwm_en); end
        checks++;
        for (int k = 1; k <= 5; k++) begin
            while (cyc < e + 4 * k) begin
                tick();
                if (a_vec() !== exp_vec(ma)) begin errors++; $display("FAIL ramp_up_model cyc=%0d got=%b exp=%b", cyc, a_vec(), exp_vec(ma)); end
                checks++;
            end
            if (int'(a_if.speed_cmd) !== k) begin errors++; $display("FAIL ramp_up_step got=%0d exp=%0d", a_if.speed_cmd, k); end
            checks++;
        end
        tick();
        if (a_if.at_target !== 1'b1 || a_if.speed_cmd !== 3'd5) begin
            errors++; $display("FAIL ramp_up_run got at=%b cmd=%0d exp at=1 cmd=5", a_if.at_target, a_if.speed_cmd);
        end
        checks++;
    endtask

    task automatic test_ramp_down();
        longint e;
        a_if.enable = 1'b0;
        tick();
        e = cyc;
        for (int k = 1; k <= 5; k++) begin
            while (cyc < e + 4 * k) begin
                tick();
                if (a_vec() !== exp_vec(ma)) begin errors++; $display("FAIL ramp_down_model cyc=%0d got=%b exp=%b", cyc, a_vec(), exp_vec(ma)); end
                checks++;
            end
            if (int'(a_if.speed_cmd) !== 5 - k) begin errors++; $display("FAIL ramp_down_step got=%0d exp=%0d", a_if.speed_cmd, 5 - k); end
            checks++;
        end
        if (a_if.pwm_en !== 1'b0 || a_if.ramping !== 1'b0) begin
            errors++; $display("FAIL ramp_down_idle got pwm=%b ramp=%b exp 0 0", a_if.pwm_en, a_if.ramping);
        end
        checks++;
    endtask

    task automatic test_reversal();
        longint e;
        int max_cmd;
        max_cmd = 0;
        a_if.enable = 1'b1; a_if.speed_target = 3'd7;
        tick();
        e = cyc;
        while (cyc < e + 25) begin
            if (cyc == e + 16) a_if.speed_target = 3'd2;
            tick();
            if (int'(a_if.speed_cmd) > max_cmd) max_cmd = int'(a_if.speed_cmd);
            if (a_vec() !== exp_vec(ma)) begin errors++; $display("FAIL reversal_model cyc=%0d got=%b exp=%b", cyc, a_vec(), exp_vec(ma)); end
            checks++;
            if (cyc == e + 16 && a_if.speed_cmd !== 3'd4) begin errors++; $display("FAIL reversal_peak got=%0d exp=4", a_if.speed_cmd); end
            if (cyc == e + 20 && a_if.speed_cmd !== 3'd3) begin errors++; $display("FAIL reversal_first got=%0d exp=3", a_if.speed_cmd); end
            if (cyc == e + 24 && a_if.speed_cmd !== 3'd2) begin errors++; $display("FAIL reversal_second got=%0d exp=2", a_if.speed_cmd); end
        end
        checks += 3;
        if (a_if.at_target !== 1'b1) begin errors++; $display("FAIL reversal_run got=%b exp=1", a_if.at_target); end
        checks++;
        if (max_cmd > 4) begin errors++; $display("FAIL reversal_overshoot got=%0d exp<=4", max_cmd); end
        checks++;
    endtask

    task automatic test_estop();
        longint e;
        a_if.speed_target = 3'd5;
        tick();
        e = cyc;
        while (cyc < e + 4) tick();
        if (a_if.speed_cmd !== 3'd3) begin errors++; $display("FAIL estop_pre got=%0d exp=3", a_if.speed_cmd); end
        checks++;
        a_if.estop = 1'b1;
        tick();
        if (a_vec() !== 7'b000_0001) begin errors++; $display("FAIL estop_hit got=%b exp=%b", a_vec(), 7'b000_0001); end
        checks++;
        a_if.estop = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        if (a_if.fault !== 1'b1 || a_if.pwm_en !== 1'b0) begin
            errors++; $display("FAIL estop_hold got fault=%b pwm=%b exp 1 0", a_if.fault, a_if.pwm_en);
        end
        checks++;
        a_if.enable = 1'b0;
        tick();
        if (a_vec() !== 7'b0) begin errors++; $display("FAIL estop_release got=%b exp=%b", a_vec(), 7'b0); end
        checks++;
    endtask

    task automatic test_reset_mid_ramp();
        longint e;
        a_if.enable = 1'b1; a_if.speed_target = 3'd6;
        tick();
        e = cyc;
        while (cyc < e + 8) tick();
        if (a_if.speed_cmd !== 3'd2) begin errors++; $display("FAIL rst_mid_pre got=%0d exp=2", a_if.speed_cmd); end
        checks++;
        rst = 1'b1;
        tick();
        if (a_vec() !== 7'b0) begin errors++; $display("FAIL rst_mid_hit got=%b exp=%b", a_vec(), 7'b0); end
        checks++;
        rst = 1'b0;
        tick();
        e = cyc;
        while (cyc < e + 4) begin
            tick();
            if (a_vec() !== exp_vec(ma)) begin errors++; $display("FAIL rst_mid_model cyc=%0d got=%b exp=%b", cyc, a_vec(), exp_vec(ma)); end
            checks++;
        end
        if (a_if.speed_cmd !== 3'd1) begin errors++; $display("FAIL rst_mid_restart got=%0d exp=1", a_if.speed_cmd); end
        checks++;
    endtask

    task automatic test_step_one();
        b_if.enable = 1'b1; b_if.speed_target = 3'd7;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (int'(b_if.speed_cmd) !== k) begin errors++; $display("FAIL step1_cmd got=%0d exp=%0d", b_if.speed_cmd, k); end
            checks++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b_if.speed_cmd !== 3'd7 || b_if.at_target !== 1'b1) begin
                errors++; $display("FAIL step1_sat got cmd=%0d at=%b exp cmd=7 at=1", b_if.speed_cmd, b_if.at_target);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                a_if.enable = ($urandom_range(0, 3) != 0);
                a_if.speed_target = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) begin
                b_if.enable = ($urandom_range(0, 3) != 0);
                b_if.speed_target = 3'($urandom_range(0, 7));
            end
            a_if.estop = ($urandom_range(0, 39) == 0);
            b_if.estop = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
            if (a_vec() !== exp_vec(ma)) begin errors++; $display("FAIL random_a cyc=%0d got=%b exp=%b", cyc, a_vec(), exp_vec(ma)); end
            checks++;
            if (b_vec() !== exp_vec(mb)) begin errors++; $display("FAIL random_b cyc=%0d got=%b exp=%b", cyc, b_vec(), exp_vec(mb)); end
            checks++;
        end
        rst = 1'b0;
    endtask

    initial begin
        ma = '{st: M_IDLE, cmd: 0, due: 0};
        mb = '{st: M_IDLE, cmd: 0, due: 0};
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_estop();
        test_reset_mid_ramp();
        test_step_one();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
